// File: rtl/oled_pkg.sv
// Shared OLED definitions: panel geometry, RGB565 pixel type and frame-reader FSM states.
package oled_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int OLED_PIXELS = 6144;

    localparam logic [15:0] OLED_CRC_INIT = 16'hFFFF;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } oled_state_t;

endpackage

// File: rtl/oled_crc16.sv
// One-word CRC-16-CCITT update (poly 0x1021, MSB-first, no reflection).
module oled_crc16
    import oled_pkg::*;
(
    input  logic [15:0] crc_in,
    input  rgb565_t     data,
    output logic [15:0] crc_out
);

    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign crc_out = crc16_word(crc_in, data);

endmodule

// File: rtl/oled_frame_reader.sv
// Raster-scans a pixel source, returns each pixel with its index, counts lit pixels per frame.
// Define OLED_FRAME_READER_CRC_EN to also produce a per-frame CRC-16-CCITT on frame_crc.
module oled_frame_reader
    import oled_pkg::*;
#(
    parameter int WIDTH       = OLED_WIDTH,
    parameter int HEIGHT      = OLED_HEIGHT,
    parameter int SRC_LATENCY = 1
) (
    input  logic        clk_mhz_6_25,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    output logic [6:0]  x,
    output logic [5:0]  y,
    input  rgb565_t     pixel_in,
    output rgb565_t     pixel_out,
    output logic [12:0] pixel_index,
    output logic        pixel_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [12:0] lit_count,
    output logic [15:0] frame_crc
);

    localparam int ACC_W = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(SRC_LATENCY - 1);

    oled_state_t state_r, state_next_s;

    logic [6:0]  x_r, x_next_s;
    logic [5:0]  y_r, y_next_s;
    logic [12:0] idx_r, idx_next_s;
    logic [2:0]  drain_cnt_r, drain_next_s;
    logic        busy_r, busy_next_s;
    logic        frame_done_r, done_next_s;
    logic        last_coord_s;

    logic [SRC_LATENCY-1:0] tag_v_r;
    logic [12:0]            tag_idx_r [SRC_LATENCY];

    rgb565_t     pixel_out_r;
    logic [12:0] pixel_index_r;
    logic        pixel_valid_r;
    logic        sample_s;
    logic        lit_inc_s;
    logic [ACC_W-1:0] lit_acc_r, lit_next_s;
    logic [12:0] lit_count_r;

    assign last_coord_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign sample_s     = tag_v_r[SRC_LATENCY-1];
    assign lit_inc_s    = sample_s && (pixel_in != 16'h0000);
    assign lit_next_s   = lit_acc_r + {{(ACC_W-1){1'b0}}, lit_inc_s};

    // FSM state register
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start only matters in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start || continuous) state_next_s = ST_SCAN;
                else                     state_next_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (last_coord_s) state_next_s = ST_DRAIN;
                else              state_next_s = ST_SCAN;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) state_next_s = ST_DONE;
                else                           state_next_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (continuous) state_next_s = ST_SCAN;
                else            state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output logic: coordinate/index stepping, drain count, status flags
    always_comb begin
        x_next_s     = 7'd0;
        y_next_s     = 6'd0;
        idx_next_s   = 13'd0;
        drain_next_s = 3'd0;
        if ((state_r == ST_SCAN) && !last_coord_s) begin
            idx_next_s = idx_r + 13'd1;
            if (x_r == X_LAST) begin
                x_next_s = 7'd0;
                y_next_s = y_r + 6'd1;
            end else begin
                x_next_s = x_r + 7'd1;
                y_next_s = y_r;
            end
        end else begin
            idx_next_s = 13'd0;
        end
        if (state_r == ST_DRAIN) begin
            drain_next_s = drain_cnt_r + 3'd1;
        end else begin
            drain_next_s = 3'd0;
        end
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_r == ST_DRAIN) && (state_next_s == ST_DONE);
    end

    // Coordinate counters and status registers
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            x_r          <= 7'd0;
            y_r          <= 6'd0;
            idx_r        <= 13'd0;
            drain_cnt_r  <= 3'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            x_r          <= x_next_s;
            y_r          <= y_next_s;
            idx_r        <= idx_next_s;
            drain_cnt_r  <= drain_next_s;
            busy_r       <= busy_next_s;
            frame_done_r <= done_next_s;
        end
    end

    // Tag pipeline matching the source latency of each emitted coordinate
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            tag_v_r <= {SRC_LATENCY{1'b0}};
            for (int i = 0; i < SRC_LATENCY; i++) tag_idx_r[i] <= 13'd0;
        end else begin
            tag_v_r[0]   <= (state_r == ST_SCAN);
            tag_idx_r[0] <= idx_r;
            for (int i = 1; i < SRC_LATENCY; i++) begin
                tag_v_r[i]   <= tag_v_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
        end
    end

    // Pixel capture
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            pixel_valid_r <= 1'b0;
            pixel_out_r   <= 16'h0000;
            pixel_index_r <= 13'd0;
        end else begin
            pixel_valid_r <= sample_s;
            if (sample_s) begin
                pixel_out_r   <= pixel_in;
                pixel_index_r <= tag_idx_r[SRC_LATENCY-1];
            end else begin
                pixel_out_r   <= pixel_out_r;
                pixel_index_r <= pixel_index_r;
            end
        end
    end

    // Lit-pixel accumulator; the final pixel lands on the same edge that enters DONE
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            lit_acc_r   <= {ACC_W{1'b0}};
            lit_count_r <= 13'd0;
        end else if (done_next_s) begin
            lit_acc_r   <= {ACC_W{1'b0}};
            lit_count_r <= 13'(lit_next_s);
        end else begin
            lit_acc_r   <= lit_next_s;
            lit_count_r <= lit_count_r;
        end
    end

`ifdef OLED_FRAME_READER_CRC_EN
    logic [15:0] crc_r, crc_upd_s, crc_next_s, frame_crc_r;

    oled_crc16 u_crc16 (
        .crc_in  (crc_r),
        .data    (pixel_in),
        .crc_out (crc_upd_s)
    );

    assign crc_next_s = sample_s ? crc_upd_s : crc_r;

    // Running CRC, latched and reseeded at frame end
    always_ff @(posedge clk_mhz_6_25) begin
        if (reset) begin
            crc_r       <= OLED_CRC_INIT;
            frame_crc_r <= 16'h0000;
        end else if (done_next_s) begin
            crc_r       <= OLED_CRC_INIT;
            frame_crc_r <= crc_next_s;
        end else begin
            crc_r       <= crc_next_s;
            frame_crc_r <= frame_crc_r;
        end
    end

    assign frame_crc = frame_crc_r;
`else
    assign frame_crc = 16'h0000;
`endif

    assign x           = x_r;
    assign y           = y_r;
    assign pixel_out   = pixel_out_r;
    assign pixel_index = pixel_index_r;
    assign pixel_valid = pixel_valid_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign lit_count   = lit_count_r;

endmodule

// File: tb/tb_oled_frame_reader.sv
// Self-checking bench for oled_frame_reader: image-array source with 1-cycle registered latency.
module tb_oled_frame_reader;

    localparam int NPIX   = 6144;
    localparam int PERIOD = 6146;

    logic        clk_mhz_6_25 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] pixel_in = 16'h0000;
    logic [15:0] pixel_out;
    logic [12:0] pixel_index;
    logic        pixel_valid;
    logic        busy;
    logic        frame_done;
    logic [12:0] lit_count;
    logic [15:0] frame_crc;

    oled_frame_reader dut (
        .clk_mhz_6_25 (clk_mhz_6_25),
        .reset        (reset),
        .start        (start),
        .continuous   (continuous),
        .x            (x),
        .y            (y),
        .pixel_in     (pixel_in),
        .pixel_out    (pixel_out),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .lit_count    (lit_count),
        .frame_crc    (frame_crc)
    );

    always #80 clk_mhz_6_25 = ~clk_mhz_6_25;

    logic [15:0] img [NPIX];

    always @(posedge clk_mhz_6_25) pixel_in <= img[int'(y) * 96 + int'(x)];

    // Monitor state, owned by the monitor process; cleared whenever test_id moves on
    int test_id = 0;
    int seen_id = 0;
    int cyc = 0;
    int vcnt, dcnt, seq_bad, exp_idx, last_idx, last_done, prev_done;
    logic [15:0] last_pix, pix84, pix85;

    always @(negedge clk_mhz_6_25) begin
        cyc++;
        if (seen_id != test_id) begin
            seen_id = test_id;
            vcnt = 0; dcnt = 0; seq_bad = 0; exp_idx = 0; last_idx = -1;
            last_done = 0; prev_done = 0;
            last_pix = 16'h0000; pix84 = 16'hDEAD; pix85 = 16'hDEAD;
        end else if (!reset) begin
            if (pixel_valid) begin
                if (int'(pixel_index) != exp_idx || int'(pixel_index) >= NPIX) seq_bad++;
                else if (pixel_out !== img[pixel_index]) seq_bad++;
                exp_idx  = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
                vcnt++;
                last_idx = int'(pixel_index);
                last_pix = pixel_out;
                if (pixel_index == 13'd84) pix84 = pixel_out;
                if (pixel_index == 13'd85) pix85 = pixel_out;
            end
            if (frame_done) begin
                dcnt++;
                prev_done = last_done;
                last_done = cyc;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame-level results derived directly from the image
    function automatic int model_lit();
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (img[i] != 16'h0000) n++;
        return n;
    endfunction

    function automatic logic [15:0] model_crc();
`ifdef OLED_FRAME_READER_CRC_EN
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < NPIX; i++) begin
            for (int b = 15; b >= 0; b--) begin
                if (c[15] ^ img[i][b]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else                   c = {c[14:0], 1'b0};
            end
        end
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            int xx = i % 96;
            int yy = i / 96;
            case (mode)
                1:       img[i] = (xx >= 85 && yy <= 10) ? 16'hFD20 : 16'h0000;
                2:       img[i] = (i == NPIX - 1) ? 16'h07E0 : 16'h0000;
                3:       img[i] = ($urandom_range(2) == 0) ? 16'($urandom) : 16'h0000;
                default: img[i] = 16'h0000;
            endcase
        end
    endtask

    task automatic new_test();
        test_id++;
        repeat (2) @(negedge clk_mhz_6_25);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_mhz_6_25);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (dcnt < target && n < budget) begin
            @(negedge clk_mhz_6_25);
            n++;
        end
        check({tag, "_done_seen"}, 32'(dcnt >= target), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_valid_count"}, 32'(vcnt), 32'(NPIX));
        check({tag, "_index_seq"}, 32'(seq_bad), 32'd0);
        check({tag, "_done_count"}, 32'(dcnt), 32'd1);
        check({tag, "_lit_count"}, 32'(lit_count), 32'(model_lit()));
        check({tag, "_frame_crc"}, 32'(frame_crc), 32'(model_crc()));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        fill(0);
        repeat (4) @(negedge clk_mhz_6_25);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_outs", {pixel_valid, busy, frame_done, pixel_index, pixel_out}, 32'd0);
        check("rst_lit_crc", {3'd0, lit_count, frame_crc}, 32'd0);
        reset = 1'b0;
        @(negedge clk_mhz_6_25);
        check("post_rst_valid", 32'(pixel_valid), 32'd0);

        // All-zero source
        new_test();
        pulse_start();
        check("zero_busy_scan", 32'(busy), 32'd1);
        wait_done("zero", 1, 7000);
        repeat (3) @(negedge clk_mhz_6_25);
        check_frame("zero");

        // Lit box in top-right corner
        fill(1);
        new_test();
        pulse_start();
        wait_done("box", 1, 7000);
        repeat (3) @(negedge clk_mhz_6_25);
        check_frame("box");
        check("box_lit_121", 32'(lit_count), 32'd121);
        check("box_pix85", 32'(pix85), 32'hFD20);
        check("box_pix84", 32'(pix84), 32'h0000);

        // Single pixel at the last coordinate
        fill(2);
        new_test();
        pulse_start();
        wait_done("corner", 1, 7000);
        repeat (3) @(negedge clk_mhz_6_25);
        check_frame("corner");
        check("corner_last_idx", 32'(last_idx), 32'd6143);
        check("corner_last_nz", 32'(last_pix != 16'h0000), 32'd1);

        // Random image, start re-pulsed mid-scan
        fill(3);
        new_test();
        pulse_start();
        repeat (2000) @(negedge clk_mhz_6_25);
        pulse_start();
        wait_done("restart", 1, 7000);
        repeat (20) @(negedge clk_mhz_6_25);
        check_frame("restart");

        // Reset abort around pixel 3000, then a clean frame
        fill(3);
        new_test();
        pulse_start();
        for (int n = 0; n < 7000 && last_idx < 3000; n++) @(negedge clk_mhz_6_25);
        check("abort_reached_3000", 32'(last_idx >= 3000), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk_mhz_6_25);
        reset = 1'b0;
        @(negedge clk_mhz_6_25);
        check("abort_no_valid", 32'(pixel_valid), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        repeat (100) @(negedge clk_mhz_6_25);
        check("abort_no_done", 32'(dcnt), 32'd0);
        new_test();
        pulse_start();
        wait_done("clean", 1, 7000);
        repeat (3) @(negedge clk_mhz_6_25);
        check_frame("clean");

        // Continuous mode frame period
        fill(3);
        new_test();
        continuous = 1'b1;
        wait_done("cont", 3, 3 * PERIOD + 100);
        check("cont_period", 32'(last_done - prev_done), 32'(PERIOD));
        check("cont_lit", 32'(lit_count), 32'(model_lit()));
        check("cont_index_seq", 32'(seq_bad), 32'd0);
        continuous = 1'b0;
        for (int n = 0; n < 7000 && busy; n++) @(negedge clk_mhz_6_25);
        check("cont_stop_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_frame_reader.md
OLED_FRAME_READER -- requirements
Module: oled_frame_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 96, display columns.
REQ-002 SHALL have parameter HEIGHT, default 64, display rows.
REQ-003 SHALL have parameter SRC_LATENCY, default 1, cycles from coordinate out to matching pixel on pixel_in (range 1..4).
REQ-004 SHALL have port clk_mhz_6_25, input, 1, clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, request one frame scan; sampled in IDLE only.
REQ-007 SHALL have port continuous, input, 1, when high, rescan automatically after each frame.
REQ-008 SHALL have port x, output, 7, column presented to the pixel source.
REQ-009 SHALL have port y, output, 6, row presented to the pixel source.
REQ-010 SHALL have port pixel_in, input, 16, RGB565 from the source.
REQ-011 SHALL have port pixel_out, output, 16, captured pixel.
REQ-012 SHALL have port pixel_index, output, 13, y*WIDTH+x of pixel_out.
REQ-013 SHALL have port pixel_valid, output, 1, pixel_out/pixel_index valid this cycle.
REQ-014 SHALL have port busy, output, 1, high in SCAN, DRAIN and DONE.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.
REQ-016 SHALL have port lit_count, output, 13, non-zero pixels counted in last completed frame.
REQ-017 SHALL have port frame_crc, output, 16, CRC of last completed frame.

Function
REQ-018 SHALL implement FSM IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start or continuous.
REQ-019 SHALL in SCAN emit one coordinate per cycle in raster order: x 0..WIDTH-1, then x wraps to 0 and y increments; first coordinate (0,0).
REQ-020 SHALL go SCAN->DRAIN in the cycle after emitting (WIDTH-1,HEIGHT-1); DRAIN lasts SRC_LATENCY cycles; then DONE for exactly 1 cycle.
REQ-021 SHALL go DONE->SCAN if continuous is high, else DONE->IDLE; start in DONE is ignored.
REQ-022 SHALL hold x=0, y=0 outside SCAN.
REQ-023 SHALL delay a valid/index tag SRC_LATENCY cycles behind each emitted coordinate, register pixel_in with it, and drive pixel_valid one cycle after pixel_in is sampled.
REQ-024 SHALL produce exactly WIDTH*HEIGHT pixel_valid pulses per frame, pixel_index 0..WIDTH*HEIGHT-1 ascending, no gaps.
REQ-025 SHALL accumulate a running count of pixels with pixel_in != 0; in DONE copy it to lit_count and clear the accumulator.
REQ-026 SHALL pulse frame_done during DONE, together with the lit_count/frame_crc update.
REQ-027 SHALL give a continuous-mode frame period of WIDTH*HEIGHT+SRC_LATENCY+1 cycles.
REQ-028 SHALL ignore start while busy; no restart and no pixel lost.
REQ-029 SHALL size the accumulator to hold WIDTH*HEIGHT without wrap.

Reset
REQ-030 SHALL on reset, in any state, go to IDLE, flush the tag pipeline and clear the accumulator and running CRC.
REQ-031 SHALL reset all outputs to 0: x, y, pixel_out, pixel_index, pixel_valid, busy, frame_done, lit_count, frame_crc.
REQ-032 SHALL emit no pixel_valid in the cycle after reset deasserts, and no frame_done for an aborted frame.

Configuration
REQ-033 SHALL, with OLED_FRAME_READER_CRC_EN defined, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over each frame's pixel words MSB-first, one word per valid cycle, latched to frame_crc in DONE.
REQ-034 SHALL, without OLED_FRAME_READER_CRC_EN, tie frame_crc to 0 and instantiate no CRC logic.

Structure
REQ-035 SHALL take OLED_WIDTH=96, OLED_HEIGHT=64, OLED_PIXELS=6144, the RGB565 pixel typedef and the FSM state encoding from shared package oled_pkg.
REQ-036 SHALL place the CRC word-update in sub-module oled_crc16, instantiated only under OLED_FRAME_READER_CRC_EN.

Verification
REQ-037 SHALL test: all-zero source, one start pulse -> 6144 pixel_valid pulses, one frame_done, lit_count=0, busy drops after DONE.
REQ-038 SHALL test: source returns 16'hFD20 when (x,y) in 11x11 box at x 85..95, y 0..10, else 0, registered 1-cycle -> lit_count=121; pixel_index 85 carries 16'hFD20 and pixel_index 84 carries 0.
REQ-039 SHALL test: source non-zero only at (95,63) -> lit_count=1; last valid has pixel_index=6143, pixel_out non-zero.
REQ-040 SHALL test: continuous=1, SRC_LATENCY=1 -> frame_done pulses exactly 6146 cycles apart.
REQ-041 SHALL test: reset asserted at pixel_index 3000, then start -> no frame_done for the aborted frame; next frame lit_count matches a full clean frame.
REQ-042 SHALL test: start re-pulsed mid-SCAN -> pixel_index sequence unbroken; only one frame_done.
